// File: rtl/serializer.sv
// Splits a 1568-bit block (eight 196-bit lanes) into 26 Gray-tagged 62-bit words.
// A one-deep pending buffer takes the next block while the current one drains.
module serializer #(
  parameter logic [43:0] PAD_VALUE = 44'h0
) (
  input  logic          clk_390p625M,
  input  logic          rst_n,
  input  logic [1567:0] data_1568bit,
  input  logic          data_valid,
  output logic          data_ready,
  input  logic          tx_ready,
  output logic          tx_valid,
  output logic [61:0]   tx_data,
  output logic [4:0]    frame_state,
  output logic          frame_tail_flag
);

  localparam int unsigned BLOCK_W   = 1568;
  localparam int unsigned LANE_W    = 196;
  localparam int unsigned WORD_W    = 62;
  localparam int unsigned STATE_W   = 5;
  localparam int unsigned LANE_WRDS = 24;
  localparam int unsigned LAST_IDX  = 26;

  typedef enum logic [STATE_W-1:0] {
    IDLE       = 5'b00000,
    FRAME1     = 5'b00001, FRAME2  = 5'b00011, FRAME3  = 5'b00010, FRAME4  = 5'b00110,
    FRAME5     = 5'b00111, FRAME6  = 5'b00101, FRAME7  = 5'b00100, FRAME8  = 5'b01100,
    FRAME9     = 5'b01101, FRAME10 = 5'b01111, FRAME11 = 5'b01110, FRAME12 = 5'b01010,
    FRAME13    = 5'b01011, FRAME14 = 5'b01001, FRAME15 = 5'b01000, FRAME16 = 5'b11000,
    FRAME17    = 5'b11001, FRAME18 = 5'b11011, FRAME19 = 5'b11010, FRAME20 = 5'b11110,
    FRAME21    = 5'b11111, FRAME22 = 5'b11101, FRAME23 = 5'b11100, FRAME24 = 5'b10100,
    FRAME25    = 5'b10101,
    FRAME_TAIL = 5'b10111
  } state_e;

  state_e               state_q, state_d;
  logic [BLOCK_W-1:0]   act_q, act_d;
  logic [BLOCK_W-1:0]   pend_q, pend_d;
  logic                 pend_full_q, pend_full_d;
  logic                 data_ready_q, data_ready_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 tail_q, tail_d;
  logic [WORD_W-1:0]    tx_data_q, tx_data_d;
  logic [STATE_W-1:0]   idx;
  logic                 load;

  // The state encoding is the reflected Gray code of the frame index.
  function automatic logic [STATE_W-1:0] gray2bin(input logic [STATE_W-1:0] g);
    logic [STATE_W-1:0] b;
    b[STATE_W-1] = g[STATE_W-1];
    for (int i = int'(STATE_W) - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [STATE_W-1:0] bin2gray(input logic [STATE_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WORD_W-1:0] word_f(input state_e st, input logic [BLOCK_W-1:0] a);
    logic [WORD_W-1:0]  w;
    logic [STATE_W-1:0] n;
    w = '0;
    n = gray2bin(st);
    for (int i = 1; i <= int'(LANE_WRDS); i++) begin
      if (n == STATE_W'(i))
        w = a[BLOCK_W - 1 - LANE_W * ((i - 1) / 3) - WORD_W * ((i - 1) % 3) -: WORD_W];
    end
    // The last 10 bits of every lane are packed into FRAME25 and FRAME_TAIL.
    if (st == FRAME25)
      w = {a[1381:1372], a[1185:1176], a[989:980], a[793:784],
           a[597:588], a[401:392], a[205:204]};
    if (st == FRAME_TAIL)
      w = {a[203:196], a[9:0], PAD_VALUE};
    return w;
  endfunction

  // Next-state, buffer handoff and registered-output precompute.
  always_comb begin
    state_d     = state_q;
    act_d       = act_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    load        = 1'b0;
    idx         = gray2bin(state_q);

    if (data_valid && data_ready) begin
      pend_d      = data_1568bit;
      pend_full_d = 1'b1;
    end

    if (idx > STATE_W'(LAST_IDX)) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      load = pend_full_q;
    end else if (tx_ready) begin
      if (state_q == FRAME_TAIL) begin
        if (pend_full_q) load = 1'b1;
        else             state_d = IDLE;
      end else begin
        state_d = state_e'(bin2gray(STATE_W'(idx + STATE_W'(1))));
      end
    end

    if (load) begin
      act_d       = pend_q;
      pend_full_d = 1'b0;
      state_d     = FRAME1;
    end

    data_ready_d = !pend_full_d;
    tx_valid_d   = (state_d != IDLE);
    tail_d       = (state_d == FRAME_TAIL);
    tx_data_d    = word_f(state_d, act_d);
  end

  always_ff @(posedge clk_390p625M) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      act_q        <= '1;
      pend_q       <= '1;
      pend_full_q  <= 1'b0;
      data_ready_q <= 1'b0;
      tx_valid_q   <= 1'b0;
      tail_q       <= 1'b0;
      tx_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      act_q        <= act_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
      data_ready_q <= data_ready_d;
      tx_valid_q   <= tx_valid_d;
      tail_q       <= tail_d;
      tx_data_q    <= tx_data_d;
    end
  end

  assign data_ready      = data_ready_q;
  assign tx_valid        = tx_valid_q;
  assign tx_data         = tx_data_q;
  assign frame_state     = state_q;
  assign frame_tail_flag = tail_q;

endmodule

// File: tb/tb_serializer.sv
// Bench for serializer: lane-level reference model feeding a word scoreboard,
// plus a deserializer model that reassembles each block for round-trip comparison.
module tb_serializer;

  localparam logic [43:0] PAD = 44'h0;

  logic          clk;
  logic          rst_n;
  logic [1567:0] din;
  logic          data_valid;
  logic          data_ready;
  logic          tx_ready;
  logic          tx_valid;
  logic [61:0]   tx_data;
  logic [4:0]    frame_state;
  logic          frame_tail_flag;

  serializer #(.PAD_VALUE(PAD)) dut (
    .clk_390p625M   (clk),
    .rst_n          (rst_n),
    .data_1568bit   (din),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .tx_ready       (tx_ready),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .frame_state    (frame_state),
    .frame_tail_flag(frame_tail_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [61:0] data;
    logic [4:0]  fs;
    logic        tail;
  } exp_t;

  logic [4:0] fs_tab [0:26] = '{
    5'b00000, 5'b00001, 5'b00011, 5'b00010, 5'b00110, 5'b00111, 5'b00101, 5'b00100,
    5'b01100, 5'b01101, 5'b01111, 5'b01110, 5'b01010, 5'b01011, 5'b01001, 5'b01000,
    5'b11000, 5'b11001, 5'b11011, 5'b11010, 5'b11110, 5'b11111, 5'b11101, 5'b11100,
    5'b10100, 5'b10101, 5'b10111};

  exp_t          sb[$];
  logic [1567:0] sent_q[$];
  logic [61:0]   rt_words[$];
  int            checks = 0;
  int            errors = 0;
  int            run_len = 0;
  int            last_run = 0;
  bit            mon_en = 0;
  bit            rand_ready = 0;
  exp_t          m_e;
  logic [79:0]   m_rem;
  logic [1567:0] m_blk;
  logic [1567:0] m_ref;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each lane gives three whole words; the 10-bit lane remainders form FRAME25/FRAME_TAIL.
  task automatic push_block(input logic [1567:0] b);
    logic [195:0] lane;
    logic [79:0]  rem;
    exp_t         e;
    for (int k = 0; k < 8; k++) begin
      lane = b[1567 - 196*k -: 196];
      for (int j = 0; j < 3; j++) begin
        e.data = lane[195 - 62*j -: 62];
        e.fs   = fs_tab[3*k + j + 1];
        e.tail = 1'b0;
        sb.push_back(e);
      end
      rem[79 - 10*k -: 10] = lane[9:0];
    end
    e.data = rem[79:18]; e.fs = fs_tab[25]; e.tail = 1'b0; sb.push_back(e);
    e.data = {rem[17:0], PAD}; e.fs = fs_tab[26]; e.tail = 1'b1; sb.push_back(e);
    sent_q.push_back(b);
  endtask

  task automatic send_block(input logic [1567:0] b, output int waited);
    waited = 0;
    @(negedge clk);
    din = b;
    data_valid = 1'b1;
    while (!data_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!data_ready) begin
      chk("send_timeout", 64'(data_ready), 64'd1);
    end else begin
      push_block(b);
      @(negedge clk);
    end
    data_valid = 1'b0;
  endtask

  task automatic wait_fs(input logic [4:0] target, input string name);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (frame_state !== target && n < 3000);
    if (frame_state !== target) chk(name, 64'(frame_state), 64'(target));
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while ((tx_valid !== 1'b0 || sb.size() != 0) && n < 5000);
    if (tx_valid !== 1'b0 || sb.size() != 0) chk("idle_timeout", 64'(sb.size()), 64'd0);
    @(negedge clk); #1;
  endtask

  // Monitor: compare presented word with scoreboard head; pop and reassemble on acceptance.
  always @(negedge clk) begin
    if (mon_en) begin
      if (tx_valid === 1'b1) begin
        run_len++;
        if (sb.size() == 0) begin
          chk("unexpected_word", 64'(frame_state), 64'd0);
        end else begin
          m_e = sb[0];
          chk("tx_data", 64'(tx_data), 64'(m_e.data));
          chk("frame_state", 64'(frame_state), 64'(m_e.fs));
          chk("tail_flag", 64'(frame_tail_flag), 64'(m_e.tail));
          if (tx_ready === 1'b1 && rst_n === 1'b1) begin
            void'(sb.pop_front());
            rt_words.push_back(tx_data);
            if (m_e.tail) begin
              if (rt_words.size() != 26 || sent_q.size() == 0) begin
                chk("roundtrip_count", 64'(rt_words.size()), 64'd26);
              end else begin
                m_rem = {rt_words[24], rt_words[25][61:44]};
                for (int k = 0; k < 8; k++)
                  m_blk[1567 - 196*k -: 196] = {rt_words[3*k], rt_words[3*k+1],
                                               rt_words[3*k+2], m_rem[79 - 10*k -: 10]};
                m_ref = sent_q.pop_front();
                checks++;
                if (m_blk !== m_ref) begin
                  errors++;
                  for (int k = 0; k < 8; k++)
                    if (m_blk[1567 - 196*k -: 196] !== m_ref[1567 - 196*k -: 196])
                      $display("FAIL roundtrip lane %0d: got %h expected %h", k,
                               m_blk[1567 - 196*k -: 196], m_ref[1567 - 196*k -: 196]);
                end
              end
              rt_words.delete();
            end
          end
        end
      end else begin
        if (run_len != 0) begin
          last_run = run_len;
          run_len = 0;
        end
        chk("idle_tx_data", 64'(tx_data), 64'd0);
        chk("idle_frame_state", 64'(frame_state), 64'd0);
        chk("idle_tail", 64'(frame_tail_flag), 64'd0);
      end
    end
  end

  always begin
    @(posedge clk); #1;
    if (rand_ready) tx_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1567:0] blk;
    logic [61:0]   hold;
    int            w;

    rst_n = 1'b0; din = '0; data_valid = 1'b0; tx_ready = 1'b1;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    chk("reset_data_ready", 64'(data_ready), 64'd0);
    chk("reset_tx_valid", 64'(tx_valid), 64'd0);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("idle_data_ready", 64'(data_ready), 64'd1);
      chk("idle_tx_valid", 64'(tx_valid), 64'd0);
    end

    // Single patterned block, latency and boundary words
    blk = '1;
    blk[1567:1506] = 62'h2AAA_AAAA_AAAA_AAAA;
    blk[9:0] = 10'h2A5;
    send_block(blk, w);
    chk("latency_gap_valid", 64'(tx_valid), 64'd0);
    @(negedge clk);
    chk("latency_frame1_fs", 64'(frame_state), 64'h01);
    chk("latency_frame1_data", 64'(tx_data), 64'h2AAA_AAAA_AAAA_AAAA);
    wait_fs(fs_tab[25], "wait_frame25");
    chk("frame25_all_ones", 64'(tx_data), 64'h3FFF_FFFF_FFFF_FFFF);
    wait_fs(fs_tab[26], "wait_tail");
    chk("tail_word", 64'(tx_data), 64'({8'hFF, 10'h2A5, 44'h0}));
    chk("tail_flag_high", 64'(frame_tail_flag), 64'd1);
    @(posedge clk); #1;
    chk("after_tail_idle", 64'(tx_valid), 64'd0);
    wait_idle();
    chk("single_run_len", 64'(last_run), 64'd26);

    // Back-to-back blocks
    for (int i = 0; i < 49; i++) blk[i*32 +: 32] = $urandom();
    send_block(blk, w);
    wait_fs(fs_tab[3], "wait_frame3");
    for (int i = 0; i < 49; i++) blk[i*32 +: 32] = $urandom();
    send_block(blk, w);
    chk("b2b_accept_wait", 64'(w), 64'd0);
    wait_idle();
    chk("b2b_run_len", 64'(last_run), 64'd52);

    // Stall at FRAME12
    for (int i = 0; i < 49; i++) blk[i*32 +: 32] = $urandom();
    send_block(blk, w);
    wait_fs(fs_tab[12], "wait_frame12");
    tx_ready = 1'b0;
    hold = tx_data;
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall_fs", 64'(frame_state), 64'(fs_tab[12]));
      chk("stall_data", 64'(tx_data), 64'(hold));
    end
    tx_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_resume_fs", 64'(frame_state), 64'(fs_tab[13]));
    wait_idle();

    // Reset in the middle of a block
    for (int i = 0; i < 49; i++) blk[i*32 +: 32] = $urandom();
    send_block(blk, w);
    wait_fs(fs_tab[17], "wait_frame17");
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_fs", 64'(frame_state), 64'd0);
    chk("midrst_valid", 64'(tx_valid), 64'd0);
    chk("midrst_data_ready", 64'(data_ready), 64'd0);
    rst_n = 1'b1;
    sb.delete();
    sent_q.delete();
    rt_words.delete();
    @(posedge clk); #1;
    chk("midrst_release_ready", 64'(data_ready), 64'd1);
    for (int i = 0; i < 49; i++) blk[i*32 +: 32] = $urandom();
    send_block(blk, w);
    @(negedge clk);
    chk("midrst_restart_fs", 64'(frame_state), 64'h01);
    wait_idle();

    // Random blocks with random downstream backpressure
    rand_ready = 1'b1;
    for (int b = 0; b < 10; b++) begin
      for (int i = 0; i < 49; i++) blk[i*32 +: 32] = $urandom();
      send_block(blk, w);
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    wait_idle();
    rand_ready = 1'b0;
    tx_ready = 1'b1;
    chk("roundtrip_all_consumed", 64'(sent_q.size()), 64'd0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
